// File: rtl/tick_selector.sv
`default_nettype none
// ============================================================================
// Module      : tick_selector
// Description : Glitch-free selector of 2^SEL_WIDTH tick-enable channels
//               derived from one free-running counter; channel i runs at
//               2^i times the base rate. Drives a tick enable and a 50% clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_selector #(
    parameter int SEL_WIDTH = 1,
    parameter int DIV_BASE  = 100000000,
    parameter int CNT_WIDTH = 27
) (
    input  logic                 in_clock,
    input  logic                 in_reset,
    input  logic [SEL_WIDTH-1:0] in_select,
    input  logic                 in_hold,
    output logic                 out_tick,
    output logic                 out_clock,
    output logic [SEL_WIDTH-1:0] out_active_sel,
    output logic                 out_pending
);

    localparam int NUM_CH = 1 << SEL_WIDTH;
    localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(DIV_BASE - 1);

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [SEL_WIDTH-1:0] req_q, req_d;
    logic [SEL_WIDTH-1:0] active_q, active_d;
    logic                 tick_q, tick_d;
    logic                 clk_q, clk_d;
    logic                 pend_q, pend_d;

    logic [NUM_CH-1:0]    term_w;
    logic                 term_act_w;

    // Channel i terminates at every multiple of its period minus one; the
    // shared counter is compared against those constants instead of keeping
    // a separate divider per channel.
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            localparam int PERIOD = DIV_BASE >> i;
            logic hit_w;

            always_comb begin
                hit_w = 1'b0;
                for (int j = 0; j < (1 << i); j++) begin
                    if (count_q == CNT_WIDTH'((j + 1) * PERIOD - 1)) begin
                        hit_w = 1'b1;
                    end
                end
            end

            assign term_w[i] = hit_w;
        end
    endgenerate

    always_comb begin
        count_d    = (count_q == C_LAST) ? '0 : count_q + 1'b1;
        req_d      = in_select;
        term_act_w = term_w[active_q];
        active_d   = active_q;
        if (term_act_w && (req_q != active_q)) begin
            active_d = req_q;
        end
        // Compared against the post-switch channel so pending clears in the
        // same cycle the new channel takes over.
        pend_d = (req_q != active_d);
        tick_d = term_act_w & ~in_hold;
        clk_d  = clk_q ^ tick_d;
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            count_q  <= '0;
            req_q    <= '0;
            active_q <= '0;
            tick_q   <= 1'b0;
            clk_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            req_q    <= req_d;
            active_q <= active_d;
            tick_q   <= tick_d;
            clk_q    <= clk_d;
            pend_q   <= pend_d;
        end
    end

    assign out_tick       = tick_q;
    assign out_clock      = clk_q;
    assign out_active_sel = active_q;
    assign out_pending    = pend_q;

endmodule
`default_nettype wire

// File: doc/tick_selector.md
Name: tick_selector

Overview:
Parametrised successor to the lab3 clock selector. Instead of muxing raw clock nets, it derives 2^SEL_WIDTH tick-enable channels from one free-running counter on the single system clock. Channel i runs at 2^i times the base rate. The block glitch-free-switches the active channel, switching only at a tick boundary of the currently active channel. It drives a one-cycle tick enable plus a 50%-duty square wave to the stopwatch counters and display logic. A hold input freezes the output.

Parameters:
SEL_WIDTH, 1, width of channel select; NUM_CH = 2^SEL_WIDTH channels (legal 1..3)
DIV_BASE, 100000000, period of channel 0 in clock cycles; must be divisible by 2^(NUM_CH-1) and >= 2^NUM_CH
CNT_WIDTH, 27, counter width; must satisfy 2^CNT_WIDTH >= DIV_BASE

Ports:
in_clock  input  1  system clock, rising edge
in_reset  input  1  asynchronous, active-high reset
in_select  input  SEL_WIDTH  requested channel; sampled every cycle
in_hold  input  1  1 = suppress ticks and freeze out_clock; counter keeps running
out_tick  output  1  one-cycle tick enable of the active channel
out_clock  output  1  toggles on every emitted tick
out_active_sel  output  SEL_WIDTH  channel currently driving out_tick
out_pending  output  1  requested channel differs from active; switch not yet applied

Behaviour:
- Reset (asynchronous, active-high, all registers): count=0, active_sel=0, req_sel=0, out_tick=0, out_clock=0, out_pending=0.
- Cycle numbering: cycle 0 is the first rising edge after in_reset deasserts. count increments every edge and wraps from DIV_BASE-1 to 0; count value in cycle k is k mod DIV_BASE.
- Channel i period: P_i = DIV_BASE >> i. term_i is true in a cycle when (count mod P_i) == P_i-1. Because every P_i divides DIV_BASE, all channels term together at count == DIV_BASE-1. Do not use per-channel counters.
- Request register:
  - req_sel <= in_select every cycle.
  - out_pending = (req_sel != active_sel), registered.
  - The last value before a boundary wins. Intermediate requests are discarded.
- Boundary switching:
  - In a cycle where term_{active_sel} is true and req_sel != active_sel, active_sel <= req_sel at the end of that cycle.
  - The tick for that boundary still belongs to the old channel.
  - No partial or shortened periods. No extra or missing tick at the switch.
- Tick output (registered, latency 1): out_tick is high in cycle k+1 iff term_{active_sel} was true in cycle k and in_hold was 0 in cycle k.
- out_clock toggles in the same cycle out_tick rises.
  - Period = 2·P_active, duty 50%.
  - When held, it freezes at its current level.
- Hold:
  - Ticks that occur while held are lost, not queued.
  - Switching still occurs at boundaries while held, so out_active_sel stays live.
- Simultaneous events:
  - A request and a boundary in the same cycle: the request is registered that cycle, so it applies at the next boundary.
  - Hold deasserts on a term cycle: hold is sampled in that same cycle as 0, so the tick is emitted.
- Reset mid-operation: all state returns to reset values immediately, including mid-period and with a switch pending. out_tick deasserts asynchronously.
- SEL_WIDTH=1 with in_select tied to the legacy adjust signal reproduces the old fast/slow behaviour, glitch-free.
- No combinational path from inputs to outputs.

Test Plan:
(All with DIV_BASE=8, SEL_WIDTH=1: P_0=8, P_1=4.)
1. Reset release, in_select=0, hold=0.
   - out_tick pulses in cycles 8, 16, 24.
   - out_clock rises in cycle 8, falls in cycle 16.
   - out_active_sel=0, out_pending=0.
2. in_select 0->1 in cycle 2 (req_sel=1 from cycle 3).
   - out_pending=1 from cycle 4.
   - Boundary at count 7: tick in cycle 8 from ch0.
   - Subsequent ticks in cycles 12, 16, 20.
   - out_active_sel=1 and out_pending=0 from cycle 8.
3. Active=1, in_select 1->0 in cycle 12 (count 4).
   - Ch1 tick still in cycle 16 (count 7 of cycle 15).
   - Switch at that boundary; next tick in cycle 24, not cycle 20.
4. in_select glitches 0->1->0 within cycles 2–4.
   - No switch at boundary 7; ticks remain at 8, 16.
   - out_pending may pulse but out_active_sel stays 0.
5. Hold cycles 6–9 on ch0.
   - No tick in cycle 8; out_clock holds 0.
   - Next tick in cycle 16.
   - A switch requested in cycle 3 still applies at cycle 7.
6. Assert in_reset asynchronously in cycle 11 with active=1 and a switch pending.
   - All outputs 0 immediately.
   - After release, behaviour matches scenario 1.
